// File: rtl/mandel_pixel_gen_if.sv
// rtl/mandel_pixel_gen_if.sv - coordinate stream from pixel generator to iterator
// Ports (signals):
//   out_val   producer -> consumer  coordinate valid
//   out_rdy   consumer -> producer  consumer ready
//   out_c_r   producer -> consumer  signed 4.23 real coordinate
//   out_c_i   producer -> consumer  signed 4.23 imaginary coordinate
//   out_x     producer -> consumer  pixel column
//   out_y     producer -> consumer  pixel row
interface mandel_pixel_gen_if #(
  parameter int H_RES = 640,
  parameter int V_RES = 480
);
  localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;

  logic                 out_val;
  logic                 out_rdy;
  logic signed [26:0]   out_c_r;
  logic signed [26:0]   out_c_i;
  logic [XW-1:0]        out_x;
  logic [YW-1:0]        out_y;

  modport master (
    output out_val, out_c_r, out_c_i, out_x, out_y,
    input  out_rdy
  );

  modport slave (
    input  out_val, out_c_r, out_c_i, out_x, out_y,
    output out_rdy
  );
endinterface

// File: rtl/mandel_pixel_gen.sv
// rtl/mandel_pixel_gen.sv - raster walker producing 4.23 complex coordinates per pixel
// Optional feature macro: MANDEL_PIXGEN_CONTINUOUS_EN (wrap to pixel (0,0) forever instead of stopping).
// Ports:
//   clk         clock
//   reset       synchronous, active-high
//   start       pulse; latches config and begins a frame (IDLE/DONE only)
//   cfg_r_min   signed 4.23 real part of pixel (0,0)
//   cfg_i_max   signed 4.23 imaginary part of pixel (0,0)
//   cfg_step    signed 4.23 coordinate delta per pixel, both axes
//   pix         master side of the coordinate stream (val/rdy, c_r, c_i, x, y)
//   busy        high while a frame is running
//   frame_done  high in DONE (one-cycle pulse per frame in continuous mode)
module mandel_pixel_gen #(
  parameter int H_RES = 640,
  parameter int V_RES = 480
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic signed [26:0] cfg_r_min,
  input  logic signed [26:0] cfg_i_max,
  input  logic signed [26:0] cfg_step,
  mandel_pixel_gen_if.master pix,
  output logic               busy,
  output logic               frame_done
);
  localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t             state, state_nx;
  logic               val, val_nx;
  logic               done, done_nx;
  logic [XW-1:0]      x, x_nx;
  logic [YW-1:0]      y, y_nx;
  logic signed [26:0] c_r, c_r_nx;
  logic signed [26:0] c_i, c_i_nx;
  logic signed [26:0] r_min, r_min_nx;
  logic signed [26:0] i_max, i_max_nx;
  logic signed [26:0] step, step_nx;
  logic               xfer;

  assign xfer = val && pix.out_rdy;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      val   <= 1'b0;
      done  <= 1'b0;
      x     <= '0;
      y     <= '0;
      c_r   <= '0;
      c_i   <= '0;
      r_min <= '0;
      i_max <= '0;
      step  <= '0;
    end else begin
      state <= state_nx;
      val   <= val_nx;
      done  <= done_nx;
      x     <= x_nx;
      y     <= y_nx;
      c_r   <= c_r_nx;
      c_i   <= c_i_nx;
      r_min <= r_min_nx;
      i_max <= i_max_nx;
      step  <= step_nx;
    end
  end

  always_comb begin
    state_nx = state;
    val_nx   = val;
    done_nx  = 1'b0;
    x_nx     = x;
    y_nx     = y;
    c_r_nx   = c_r;
    c_i_nx   = c_i;
    r_min_nx = r_min;
    i_max_nx = i_max;
    step_nx  = step;

    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nx = ST_RUN;
          val_nx   = 1'b1;
          r_min_nx = cfg_r_min;
          i_max_nx = cfg_i_max;
          step_nx  = cfg_step;
          x_nx     = '0;
          y_nx     = '0;
          c_r_nx   = cfg_r_min;
          c_i_nx   = cfg_i_max;
        end
      end
      ST_RUN: begin
        // start is deliberately not looked at here, including on the last transfer.
        if (xfer) begin
          if (x == X_LAST) begin
            if (y == Y_LAST) begin
`ifdef MANDEL_PIXGEN_CONTINUOUS_EN
              x_nx    = '0;
              y_nx    = '0;
              c_r_nx  = r_min;
              c_i_nx  = i_max;
              done_nx = 1'b1;
`else
              // Coordinates and address hold the last pixel's values.
              state_nx = ST_DONE;
              val_nx   = 1'b0;
`endif
            end else begin
              x_nx   = '0;
              y_nx   = y + YW'(1);
              c_r_nx = r_min;
              c_i_nx = c_i - step;
            end
          end else begin
            x_nx   = x + XW'(1);
            c_r_nx = c_r + step;
          end
        end
      end
      default: begin
        state_nx = ST_IDLE;
        val_nx   = 1'b0;
      end
    endcase

`ifndef MANDEL_PIXGEN_CONTINUOUS_EN
    done_nx = (state_nx == ST_DONE);
`endif
  end

  assign pix.out_val = val;
  assign pix.out_c_r = c_r;
  assign pix.out_c_i = c_i;
  assign pix.out_x   = x;
  assign pix.out_y   = y;
  assign busy        = (state == ST_RUN);
  assign frame_done  = done;
endmodule

// File: tb/tb_mandel_pixel_gen.sv
// tb/tb_mandel_pixel_gen.sv - directed self-checking bench for mandel_pixel_gen (H_RES=4, V_RES=3)
module tb_mandel_pixel_gen;
  localparam int H = 4;
  localparam int V = 3;
  localparam int N = H * V;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic signed [26:0] cfg_r_min;
  logic signed [26:0] cfg_i_max;
  logic signed [26:0] cfg_step;
  logic               busy;
  logic               frame_done;

  int checks   = 0;
  int failures = 0;

  logic [26:0] exp_cr [H];
  logic [26:0] exp_ci [V];

  mandel_pixel_gen_if #(.H_RES(H), .V_RES(V)) pix ();

  mandel_pixel_gen #(.H_RES(H), .V_RES(V)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .cfg_r_min  (cfg_r_min),
    .cfg_i_max  (cfg_i_max),
    .cfg_step   (cfg_step),
    .pix        (pix),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic do_start(input logic [26:0] r, input logic [26:0] i, input logic [26:0] s);
    cfg_r_min = r;
    cfg_i_max = i;
    cfg_step  = s;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    cfg_r_min = 27'h1234567;
    cfg_i_max = 27'h7654321;
    cfg_step  = 27'h0111111;
  endtask

  task automatic check_pixel(input string tag, input int idx);
    check($sformatf("%s_x%0d", tag, idx), {62'd0, pix.out_x}, 64'(idx % H));
    check($sformatf("%s_y%0d", tag, idx), {62'd0, pix.out_y}, 64'(idx / H));
    check($sformatf("%s_cr%0d", tag, idx), {37'd0, pix.out_c_r}, {37'd0, exp_cr[idx % H]});
    check($sformatf("%s_ci%0d", tag, idx), {37'd0, pix.out_c_i}, {37'd0, exp_ci[idx / H]});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          idx;
    logic        held;
    logic [1:0]  hx, hy;
    logic [26:0] hcr, hci;
    logic        rdy;

    // -2.0, -1.5, -1.0, -0.5 and 1.0, 0.5, 0.0 in 4.23
    exp_cr[0] = 27'h7000000;
    exp_cr[1] = 27'h7400000;
    exp_cr[2] = 27'h7800000;
    exp_cr[3] = 27'h7C00000;
    exp_ci[0] = 27'h0800000;
    exp_ci[1] = 27'h0400000;
    exp_ci[2] = 27'h0000000;

    reset       = 1'b1;
    start       = 1'b0;
    cfg_r_min   = '0;
    cfg_i_max   = '0;
    cfg_step    = '0;
    pix.out_rdy = 1'b0;

    // Reset state after idling
    do_reset();
    repeat (5) tick();
    check("rst_val",  {63'd0, pix.out_val}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, frame_done}, 64'd0);
    check("rst_x",    {62'd0, pix.out_x}, 64'd0);
    check("rst_y",    {62'd0, pix.out_y}, 64'd0);
    check("rst_cr",   {37'd0, pix.out_c_r}, 64'd0);
    check("rst_ci",   {37'd0, pix.out_c_i}, 64'd0);

    // Full frame, no backpressure
    pix.out_rdy = 1'b1;
    do_start(27'h7000000, 27'h0800000, 27'h0400000);
    for (int i = 0; i < N; i++) begin
      check($sformatf("ff_val%0d", i), {63'd0, pix.out_val}, 64'd1);
      check($sformatf("ff_busy%0d", i), {63'd0, busy}, 64'd1);
      check_pixel("ff", i);
      tick();
    end
`ifdef MANDEL_PIXGEN_CONTINUOUS_EN
    check("ff_wrap_val",  {63'd0, pix.out_val}, 64'd1);
    check("ff_wrap_done", {63'd0, frame_done}, 64'd1);
    check("ff_wrap_busy", {63'd0, busy}, 64'd1);
    check_pixel("ff_wrap", 0);
    tick();
    check("ff_wrap_done2", {63'd0, frame_done}, 64'd0);
    check("ff_wrap_val2",  {63'd0, pix.out_val}, 64'd1);
    check_pixel("ff_wrap", 1);
`else
    check("ff_end_val",  {63'd0, pix.out_val}, 64'd0);
    check("ff_end_done", {63'd0, frame_done}, 64'd1);
    check("ff_end_busy", {63'd0, busy}, 64'd0);
    check_pixel("ff_end", N - 1);
    tick();
    check("ff_end_done2", {63'd0, frame_done}, 64'd1);
    check("ff_end_val2",  {63'd0, pix.out_val}, 64'd0);
`endif

    // Random backpressure with an ignored start pulse mid-frame
    do_reset();
    pix.out_rdy = 1'b0;
    do_start(27'h7000000, 27'h0800000, 27'h0400000);
    idx  = 0;
    held = 1'b0;
    hx = '0; hy = '0; hcr = '0; hci = '0;
    for (int cyc = 0; cyc < 400 && idx < N; cyc++) begin
      rdy = 1'($urandom_range(0, 1));
      pix.out_rdy = rdy;
      if (cyc == 2 || cyc == 7) begin
        start     = 1'b1;
        cfg_r_min = 27'h0100000;
        cfg_i_max = 27'h7F00000;
        cfg_step  = 27'h0010000;
      end else begin
        start = 1'b0;
      end
      check($sformatf("bp_val_c%0d", cyc), {63'd0, pix.out_val}, 64'd1);
      if (held) begin
        check($sformatf("bp_hold_x_c%0d", cyc),  {62'd0, pix.out_x}, {62'd0, hx});
        check($sformatf("bp_hold_y_c%0d", cyc),  {62'd0, pix.out_y}, {62'd0, hy});
        check($sformatf("bp_hold_cr_c%0d", cyc), {37'd0, pix.out_c_r}, {37'd0, hcr});
        check($sformatf("bp_hold_ci_c%0d", cyc), {37'd0, pix.out_c_i}, {37'd0, hci});
      end
      if (pix.out_val && rdy) begin
        check_pixel("bp", idx);
        idx++;
      end
      held = pix.out_val && !rdy;
      hx   = pix.out_x;
      hy   = pix.out_y;
      hcr  = pix.out_c_r;
      hci  = pix.out_c_i;
      tick();
    end
    start = 1'b0;
    check("bp_count", 64'(idx), 64'(N));

    // Reset mid-frame, then a clean restart
    do_reset();
    pix.out_rdy = 1'b1;
    do_start(27'h7000000, 27'h0800000, 27'h0400000);
    repeat (5) tick();
    check_pixel("mid", 5);
    reset = 1'b1;
    tick();
    check("mid_rst_val",  {63'd0, pix.out_val}, 64'd0);
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_x",    {62'd0, pix.out_x}, 64'd0);
    check("mid_rst_cr",   {37'd0, pix.out_c_r}, 64'd0);
    reset = 1'b0;
    tick();
    check("mid_idle_val", {63'd0, pix.out_val}, 64'd0);
    do_start(27'h7800000, 27'h0000000, 27'h0200000);
    check("rs_val", {63'd0, pix.out_val}, 64'd1);
    check("rs_x",   {62'd0, pix.out_x}, 64'd0);
    check("rs_y",   {62'd0, pix.out_y}, 64'd0);
    check("rs_cr",  {37'd0, pix.out_c_r}, 64'h7800000);
    check("rs_ci",  {37'd0, pix.out_c_i}, 64'h0000000);
    tick();
    check("rs_x1",  {62'd0, pix.out_x}, 64'd1);
    check("rs_cr1", {37'd0, pix.out_c_r}, 64'h7A00000);
    check("rs_ci1", {37'd0, pix.out_c_i}, 64'h0000000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
